// File: rtl/ram_stream_reader_if.sv
// Handshake/bus bundle for ram_stream_reader: command, RAM port-B read side and output stream.
// The reader drives through "master"; the surrounding system/RAM uses "slave".
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
);
  logic                  io_start;
  logic [ADDR_WIDTH-1:0] io_base;
  logic [ADDR_WIDTH-1:0] io_stride;
  logic [LEN_WIDTH-1:0]  io_len;
  logic                  io_busy;
  logic                  io_done;
  logic                  io_enb;
  logic [ADDR_WIDTH-1:0] io_addrb;
  logic [DATA_WIDTH-1:0] io_doutb;
  logic                  io_out_valid;
  logic                  io_out_ready;
  logic [DATA_WIDTH-1:0] io_out_data;
  logic                  io_out_last;

  modport master (
    input  io_start, io_base, io_stride, io_len, io_doutb, io_out_ready,
    output io_busy, io_done, io_enb, io_addrb, io_out_valid, io_out_data, io_out_last
  );

  modport slave (
    output io_start, io_base, io_stride, io_len, io_doutb, io_out_ready,
    input  io_busy, io_done, io_enb, io_addrb, io_out_valid, io_out_data, io_out_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Strided read sequencer for a 2-cycle-latency RAM port B, streaming the returned words
// through a credit-limited show-ahead FIFO so backpressure never drops a word.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clock,
  input logic              reset_n,
  ram_stream_reader_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  k_q;
  logic [1:0]            vld_q;
  logic [1:0]            lst_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] mem_q  [FIFO_DEPTH];
  logic                  lmem_q [FIFO_DEPTH];

  logic                  accept, issue, last_issue, push, pop, credit_ok, out_valid;
  logic [CNT_W:0]        occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & bus.io_out_ready;
  assign push      = vld_q[1];
  assign accept    = (state_q == S_IDLE) & bus.io_start;

  // Occupancy counts buffered words plus words still inside the RAM pipeline; a pop this
  // cycle frees a slot, and occupancy never exceeds FIFO_DEPTH, so a pop always permits issue.
  assign occ       = {1'b0, cnt_q} + (CNT_W+1)'(vld_q[0]) + (CNT_W+1)'(vld_q[1]);
  assign credit_ok = pop | (occ < (CNT_W+1)'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    last_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.io_start) state_d = (bus.io_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (credit_ok) begin
          issue      = 1'b1;
          last_issue = (k_q == len_q - LEN_WIDTH'(1));
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last-marked word is the final one queued, so its handshake ends the transfer.
        if (pop && lmem_q[rd_ptr_q]) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      k_q      <= '0;
      vld_q    <= '0;
      lst_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.io_base;
        stride_q <= bus.io_stride;
        len_q    <= bus.io_len;
        k_q      <= '0;
      end else if (issue) begin
        addr_q <= addr_q + stride_q;
        k_q    <= k_q + LEN_WIDTH'(1);
      end
      vld_q <= {vld_q[0], issue};
      lst_q <= {lst_q[0], last_issue};
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage carries data only; validity comes from the reset-controlled count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q]  <= bus.io_doutb;
      lmem_q[wr_ptr_q] <= lst_q[1];
    end
  end

  assign bus.io_busy      = (state_q != S_IDLE);
  assign bus.io_done      = (state_q == S_DONE);
  assign bus.io_enb       = issue;
  assign bus.io_addrb     = addr_q;
  assign bus.io_out_valid = out_valid;
  assign bus.io_out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.io_out_last  = out_valid & lmem_q[rd_ptr_q];
endmodule
